// File: rtl/wb_arbiter_2x1.sv
// Two-master, one-slave Wishbone arbiter.
// A three-state FSM hands the shared slave to one master at a time, alternating on
// ties. A grant is held for as long as the owner keeps cyc high, so locked sequences
// such as read-modify-write are never split. Every grant change passes through IDLE.
// A strobe watchdog ends a transfer with a one-cycle error when the slave stays silent.
module wb_arbiter_2x1 #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int GRANULE     = 8,
    parameter int TIMEOUT     = 16,
    localparam int SEL_WIDTH  = DATA_WIDTH / GRANULE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    input  logic [SEL_WIDTH-1:0]  m0_sel_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic [DATA_WIDTH-1:0] m0_dat_o,

    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    input  logic [SEL_WIDTH-1:0]  m1_sel_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic [DATA_WIDTH-1:0] m1_dat_o,

    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    output logic [SEL_WIDTH-1:0]  s_sel_o,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic [DATA_WIDTH-1:0] s_dat_i,

    output logic [1:0]            gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Counter value at which the next unanswered strobe edge fires the error.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    logic       last_grant_q;   // 0: master 0 was granted last, 1: master 1
    logic       last_grant_d;
    logic [7:0] tmo_cnt_q;
    logic       tmo_err_q;
    logic       strobe_unanswered;
    logic       state_change;

    assign strobe_unanswered = s_stb_o & ~s_ack_i & ~s_err_i;
    assign state_change      = (state_d != state_q);

    // Response data is broadcast; only ack/err are steered to the owner.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // Next-state decision: tie goes to the master that was not granted last.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (last_grant_q) begin
                        state_d      = GNT0;
                        last_grant_d = 1'b0;
                    end else begin
                        state_d      = GNT1;
                        last_grant_d = 1'b1;
                    end
                end else if (m0_cyc_i) begin
                    state_d      = GNT0;
                    last_grant_d = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d      = GNT1;
                    last_grant_d = 1'b1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant state and round-robin memory; reset favours master 0 on the first tie.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Strobe watchdog: counts silent strobe edges and fires a single-cycle error.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tmo_cnt_q <= 8'd0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_err_q <= 1'b0;
            if (state_change || !strobe_unanswered) begin
                tmo_cnt_q <= 8'd0;
            end else if (tmo_cnt_q == TMO_LAST) begin
                tmo_cnt_q <= 8'd0;
                tmo_err_q <= 1'b1;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
        end
    end

    // Slave-side mux and response steering; the strobe is withheld during the error cycle.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        gnt_o    = 2'b00;
        case (state_q)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~tmo_err_q;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | tmo_err_q;
                gnt_o    = 2'b01;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~tmo_err_q;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | tmo_err_q;
                gnt_o    = 2'b10;
            end
            default: begin
            end
        endcase
    end

endmodule
